// File: rtl/fd_pkg.sv
// Shared definitions for the LC-3 style fetch/decode front end:
// opcodes, instruction-class encoding, FSM states and the reset PC.
package fd_pkg;

    localparam logic [15:0] RESET_PC_DEF = 16'h3000;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RSVD = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    // Instruction class is {imm_flag, opcode}; imm_flag only ever set for ADD/AND.
    typedef logic [4:0] itype_t;

    localparam int NUM_WB_TYPES = 11;
    localparam itype_t WB_TYPES [NUM_WB_TYPES] = '{
        5'b00001, 5'b10001, 5'b00101, 5'b10101, 5'b01001, 5'b00010,
        5'b01010, 5'b00110, 5'b01110, 5'b00100, 5'b01111
    };

    function automatic logic is_wb_type(input itype_t t);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_WB_TYPES; i++)
            if (WB_TYPES[i] == t) hit = 1'b1;
        return hit;
    endfunction

    localparam logic [1:0] S_RST_IDLE = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_OUT      = 2'd2;
    localparam logic [1:0] S_WAIT_NPC = 2'd3;

endpackage

// File: rtl/fetch_decode_inst_decoder.sv
// Combinational LC-3 instruction decoder: splits a 16-bit word into class,
// register indices and extended immediate. Unused fields stay zero.
module inst_decoder
    import fd_pkg::*;
(
    input  logic [15:0] word,
    output itype_t      inst_type,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic [15:0] imm,
    output logic        illegal
);
    logic [3:0] op;
    assign op = word[15:12];

    always_comb begin
        inst_type = {1'b0, op};
        SR1       = 3'd0;
        SR2       = 3'd0;
        DR        = 3'd0;
        imm       = 16'd0;
        illegal   = 1'b0;
        case (op)
            OP_ADD, OP_AND: begin
                inst_type = {word[5], op};
                SR1       = word[8:6];
                DR        = word[11:9];
                if (word[5]) imm = {{11{word[4]}}, word[4:0]};
                else         SR2 = word[2:0];
            end
            OP_NOT: begin
                SR1 = word[8:6];
                DR  = word[11:9];
            end
            OP_LDR: begin
                SR1 = word[8:6];
                DR  = word[11:9];
                imm = {{10{word[5]}}, word[5:0]};
            end
            OP_STR: begin
                SR1 = word[8:6];
                SR2 = word[11:9];
                imm = {{10{word[5]}}, word[5:0]};
            end
            OP_JMP: SR1 = word[8:6];
            OP_JSR: begin
                DR = 3'd7;
                if (word[11]) imm = {{5{word[10]}}, word[10:0]};
                else          SR1 = word[8:6];
            end
            OP_BR: imm = {{7{word[8]}}, word[8:0]};
            OP_LD, OP_LDI, OP_LEA: begin
                DR  = word[11:9];
                imm = {{7{word[8]}}, word[8:0]};
            end
            OP_ST, OP_STI: begin
                SR2 = word[11:9];
                imm = {{7{word[8]}}, word[8:0]};
            end
            OP_TRAP: begin
                DR  = 3'd7;
                imm = {8'd0, word[7:0]};
            end
            OP_RSVD: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Single-issue fetch/decode front end: fetches at PC, registers the decoded
// word, hands it to execute and waits for next_IP before fetching again.
module fetch_decode
    import fd_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [15:0] inst,
    output itype_t      inst_type,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic [15:0] imm,
    output logic [15:0] IP,
    output logic        illegal,
    input  logic [15:0] next_IP,
    input  logic        next_ip_valid
);
    logic [1:0]  state;
    logic [15:0] pc;
    itype_t      d_type;
    logic [2:0]  d_sr1, d_sr2, d_dr;
    logic [15:0] d_imm;
    logic        d_illegal;

    inst_decoder u_dec (
        .word      (imem_rdata),
        .inst_type (d_type),
        .SR1       (d_sr1),
        .SR2       (d_sr2),
        .DR        (d_dr),
        .imm       (d_imm),
        .illegal   (d_illegal)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RST_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            dec_valid <= 1'b0;
            inst      <= 16'd0;
            inst_type <= '0;
            SR1       <= 3'd0;
            SR2       <= 3'd0;
            DR        <= 3'd0;
            imm       <= 16'd0;
            IP        <= RESET_PC;
            illegal   <= 1'b0;
        end else begin
            case (state)
                // One dead cycle so a stale imem_valid from before reset is never taken.
                S_RST_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: if (imem_valid) begin
                    inst      <= imem_rdata;
                    inst_type <= d_type;
                    SR1       <= d_sr1;
                    SR2       <= d_sr2;
                    DR        <= d_dr;
                    imm       <= d_imm;
                    illegal   <= d_illegal;
                    IP        <= pc;
                    imem_req  <= 1'b0;
                    dec_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: if (dec_ready) begin
                    dec_valid <= 1'b0;
                    if (next_ip_valid) begin
                        pc       <= next_IP;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_WAIT_NPC;
                    end
                end
                S_WAIT_NPC: if (next_ip_valid) begin
                    pc       <= next_IP;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    imem_req  <= 1'b0;
                    dec_valid <= 1'b0;
                    state     <= S_RST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Vector/scoreboard bench for fetch_decode: table of instruction words with
// expected decode, plus reset-in-flight sequences.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] inst;
    logic [4:0]  inst_type;
    logic [2:0]  SR1, SR2, DR;
    logic [15:0] imm;
    logic [15:0] IP;
    logic        illegal;
    logic [15:0] next_IP;
    logic        next_ip_valid;

    fetch_decode dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .inst(inst), .inst_type(inst_type),
        .SR1(SR1), .SR2(SR2), .DR(DR), .imm(imm), .IP(IP), .illegal(illegal),
        .next_IP(next_IP), .next_ip_valid(next_ip_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        int          wt;
        int          hold;
        int          dly;
        logic [15:0] npc;
        logic [4:0]  typ;
        logic [2:0]  sr1, sr2, dr;
        logic [15:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [15:0] inst;
        logic [4:0]  typ;
        logic [2:0]  sr1, sr2, dr;
        logic [15:0] imm;
        logic        ill;
        logic [15:0] ip;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 16'h3000);
        chk("rst_dv", dec_valid, 0);
        chk("rst_ip", IP, 16'h3000);
        chk("rst_fields", {inst, inst_type, SR1, SR2, DR, imm, illegal}, 0);
    endtask

    // Wait for a fetch, optionally stall, return the word and score the decode.
    task automatic do_fetch(input logic [15:0] word, input int wt, input exp_t e);
        exp_t got;
        int   n;
        n = 0;
        while (!imem_req && n < 20) begin step(); n++; end
        chk("req_seen", imem_req, 1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < wt; i++) begin
            if (i == 1) begin next_ip_valid = 1; next_IP = 16'hBEEF; end
            step();
            next_ip_valid = 0;
            chk("stall_req_addr", {imem_req, imem_addr}, {1'b1, exp_pc});
            chk("stall_dv", dec_valid, 0);
        end
        imem_valid = 1;
        imem_rdata = word;
        sb_q.push_back(e);
        step();
        imem_valid = 0;
        imem_rdata = 16'($urandom);
        chk("dec_valid", dec_valid, 1);
        chk("req_dropped", imem_req, 0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb_q.pop_front();
            chk("inst", inst, got.inst);
            chk("type", inst_type, got.typ);
            chk("regs", {SR1, SR2, DR}, {got.sr1, got.sr2, got.dr});
            chk("imm", imm, got.imm);
            chk("illegal", illegal, got.ill);
            chk("ip", IP, got.ip);
        end
    endtask

    task automatic do_ship(input int hold, input int dly, input logic [15:0] npc);
        logic [47:0] snap;
        snap = {inst, imm, IP};
        for (int i = 0; i < hold; i++) begin
            // next_ip_valid without a handshake must be ignored
            if (i == 0) begin next_ip_valid = 1; next_IP = 16'hDEAD; end
            step();
            next_ip_valid = 0;
            chk("hold_dv_req", {dec_valid, imem_req}, 2'b10);
            chk("hold_frozen", {inst, imm, IP}, snap);
        end
        dec_ready = 1;
        if (dly == 0) begin next_ip_valid = 1; next_IP = npc; end
        step();
        dec_ready = 0;
        next_ip_valid = 0;
        if (dly != 0) begin
            chk("wait_npc", {dec_valid, imem_req}, 2'b00);
            repeat (dly - 1) step();
            next_ip_valid = 1;
            next_IP = npc;
            step();
            next_ip_valid = 0;
        end
        chk("npc_fetch", {imem_req, imem_addr}, {1'b1, npc});
        exp_pc = npc;
    endtask

    vec_t vecs[13];
    exp_t e;

    initial begin
        //          word      wt hold dly npc       type      sr1  sr2  dr   imm       ill
        vecs[0]  = '{16'h1261, 0, 0, 0, 16'h3001, 5'b10001, 3'd1, 3'd0, 3'd1, 16'h0001, 1'b0};
        vecs[1]  = '{16'h25FF, 4, 3, 0, 16'h3002, 5'b00010, 3'd0, 3'd0, 3'd2, 16'hFFFF, 1'b0};
        vecs[2]  = '{16'h4FFF, 1, 0, 2, 16'hFFFF, 5'b00100, 3'd0, 3'd0, 3'd7, 16'hFFFF, 1'b0};
        vecs[3]  = '{16'hD000, 0, 1, 0, 16'h0000, 5'b01101, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1};
        vecs[4]  = '{16'hF025, 2, 0, 1, 16'h0010, 5'b01111, 3'd0, 3'd0, 3'd7, 16'h0025, 1'b0};
        vecs[5]  = '{16'h1A07, 0, 0, 0, 16'h0011, 5'b00001, 3'd0, 3'd7, 3'd5, 16'h0000, 1'b0};
        vecs[6]  = '{16'h7BA0, 1, 0, 0, 16'h0012, 5'b00111, 3'd6, 3'd5, 3'd0, 16'hFFE0, 1'b0};
        vecs[7]  = '{16'hC1C0, 0, 0, 0, 16'h0013, 5'b01100, 3'd7, 3'd0, 3'd0, 16'h0000, 1'b0};
        vecs[8]  = '{16'h5AB0, 0, 0, 0, 16'h0014, 5'b10101, 3'd2, 3'd0, 3'd5, 16'hFFF0, 1'b0};
        vecs[9]  = '{16'h4280, 0, 0, 0, 16'h0015, 5'b00100, 3'd2, 3'd0, 3'd7, 16'h0000, 1'b0};
        vecs[10] = '{16'h0E05, 0, 0, 0, 16'h0016, 5'b00000, 3'd0, 3'd0, 3'd0, 16'h0005, 1'b0};
        vecs[11] = '{16'hB7FE, 0, 0, 0, 16'h0017, 5'b01011, 3'd0, 3'd3, 3'd0, 16'hFFFE, 1'b0};
        vecs[12] = '{16'h967F, 0, 0, 0, 16'h0018, 5'b01001, 3'd1, 3'd0, 3'd3, 16'h0000, 1'b0};

        rst_n = 0; imem_valid = 0; imem_rdata = 0; dec_ready = 0;
        next_IP = 0; next_ip_valid = 0;
        exp_pc = 16'h3000;
        repeat (2) step();
        chk_reset_vals();
        rst_n = 1;
        #2;
        chk("idle_req", imem_req, 0);
        step();
        chk("first_req", {imem_req, imem_addr}, {1'b1, 16'h3000});
        chk("first_dv", dec_valid, 0);

        foreach (vecs[k]) begin
            e = '{vecs[k].word, vecs[k].typ, vecs[k].sr1, vecs[k].sr2,
                  vecs[k].dr, vecs[k].imm, vecs[k].ill, exp_pc};
            do_fetch(vecs[k].word, vecs[k].wt, e);
            do_ship(vecs[k].hold, vecs[k].dly, vecs[k].npc);
        end

        // Reset while in WAIT_NPC
        e = '{16'h1261, 5'b10001, 3'd1, 3'd0, 3'd1, 16'h0001, 1'b0, exp_pc};
        do_fetch(16'h1261, 0, e);
        dec_ready = 1;
        step();
        dec_ready = 0;
        chk("pre_rst_wait", {dec_valid, imem_req}, 2'b00);
        #2 rst_n = 0;
        #1;
        chk_reset_vals();
        step();
        rst_n = 1;
        imem_valid = 1;             // stale valid during RST_IDLE
        imem_rdata = 16'hF0FF;
        step();
        imem_valid = 0;
        chk("restart_req", {imem_req, imem_addr}, {1'b1, 16'h3000});
        step();
        chk("stale_not_taken", {dec_valid, inst}, {1'b0, 16'h0000});

        // Reset during a FETCH wait state
        step();
        #2 rst_n = 0;
        #1;
        chk_reset_vals();
        step();
        rst_n = 1;
        exp_pc = 16'h3000;
        e = '{16'hF025, 5'b01111, 3'd0, 3'd0, 3'd7, 16'h0025, 1'b0, 16'h3000};
        do_fetch(16'hF025, 1, e);
        do_ship(0, 0, 16'h3001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front end of the 16-bit LC-3-style core. It fetches one instruction word from instruction memory at the current program counter and decodes it into the operand fields the execute stage consumes: `inst`, `type`, `SR1`, `SR2`, `DR`, `imm` and `IP`. It then holds those fields under a valid/ready handshake and waits for execute to return `next_IP` before fetching again. The core is strictly one instruction in flight.

## Interface
- `RESET_PC`, default 16'h3000: program counter after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held until `imem_valid`.
- `imem_addr`  out  16  fetch address, equal to PC.
- `imem_rdata`  in  16  instruction word, qualified by `imem_valid`.
- `imem_valid`  in  1  read data valid; sampled only while `imem_req`=1.
- `dec_valid`  out  1  decoded fields are valid.
- `dec_ready`  in  1  execute accepts the fields.
- `inst`  out  16  raw instruction word.
- `type`  out  5  instruction class: {imm_flag, opcode}.
- `SR1`, `SR2`, `DR`  out  3 each  source and destination register indices.
- `imm`  out  16  sign- or zero-extended immediate.
- `IP`  out  16  address of the decoded instruction.
- `illegal`  out  1  reserved opcode 4'b1101.
- `next_IP`  in  16  PC for the next fetch, from execute.
- `next_ip_valid`  in  1  `next_IP` qualifier; a single-cycle pulse.

## Operation
- FSM states: RST_IDLE → FETCH → OUT → WAIT_NPC → FETCH.
- RST_IDLE: lasts exactly one cycle after reset release, with `imem_req`=0. This prevents a stale `imem_valid` from being captured.
- FETCH: `imem_req`=1, `imem_addr`=PC.
  - On `imem_valid`, register `imem_rdata` and its decode, set `IP`=PC, and go to OUT.
- OUT: `dec_valid`=1 and all outputs are frozen.
  - On `dec_valid && dec_ready`: if `next_ip_valid` is also high, set PC←`next_IP` and go to FETCH; otherwise go to WAIT_NPC.
- WAIT_NPC: `dec_valid`=0. On `next_ip_valid`, set PC←`next_IP` and go to FETCH.
- `next_ip_valid` is ignored in RST_IDLE and FETCH, and in OUT without a handshake.
- Decode, where op = `inst[15:12]`:
  - `type[3:0]`=op.
  - `type[4]`=`inst[5]` for ADD (0001) and AND (0101); 0 for all other opcodes.
  - `SR1`=`inst[8:6]` for ADD, AND, NOT, LDR, STR, JMP, and JSRR (JSR with `inst[11]`=0).
  - `SR2`=`inst[2:0]` for ADD/AND register form; `SR2`=`inst[11:9]` for ST, STI, STR.
  - `DR`=`inst[11:9]` for ADD, AND, NOT, LD, LDI, LDR, LEA; `DR`=7 for JSR/JSRR and TRAP.
  - `imm`:
    - sext(`inst[4:0]`) for ADD/AND immediate form.
    - sext(`inst[8:0]`) for BR, LD, LDI, ST, STI, LEA.
    - sext(`inst[5:0]`) for LDR, STR.
    - sext(`inst[10:0]`) for JSR with `inst[11]`=1.
    - zext(`inst[7:0]`) for TRAP.
  - Any field not listed for an opcode is 0.
  - `illegal`=1 only for op 1101; that word is still presented normally.
- PC arithmetic is 16-bit and wraps: PC 16'hFFFF is legal and is fetched as-is.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `dec_valid`=0, `IP`=`RESET_PC`.
  - `inst`, `type`, `SR1`, `SR2`, `DR`, `imm` all 0; `illegal`=0.
  - State RST_IDLE.
- `imem_valid` may arrive in the same cycle `imem_req` rises (zero wait states) or any number of cycles later.
- `imem_req` and `imem_addr` are stable until `imem_valid` is seen.
- Latency: `dec_valid` rises on the cycle after the `imem_valid` capture edge.
- Minimum issue interval is 2 cycles per instruction: FETCH with immediate valid, then OUT with ready and `next_ip_valid` together.
- While `dec_valid && !dec_ready`, all decode outputs are stable and `imem_req`=0.
- Asserting `rst_n` low in any state returns every output to its reset value immediately; no partial handshake survives.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `fd_pkg` holds:
  - opcode localparams (OP_BR … OP_TRAP, OP_RSVD);
  - the `type` encoding and the write-back class list (00001, 10001, 00101, 10101, 01001, 00010, 01010, 00110, 01110, 00100, 01111);
  - FSM state encoding;
  - the `RESET_PC` default.
- One sub-module, `inst_decoder`: purely combinational, taking a 16-bit word and producing `type`, `SR1`, `SR2`, `DR`, `imm`, `illegal`.
- `fetch_decode` owns the FSM, PC and output registers.

## Test plan
- Reset release → one cycle with `imem_req`=0, then `imem_req`=1 with `imem_addr`=16'h3000; outputs all at reset values.
- Return 16'h1261 at 3000 with zero wait → next cycle `dec_valid`=1, `type`=10001, `DR`=1, `SR1`=1, `imm`=0001, `IP`=3000.
- Return 16'h25FF with `imem_valid` delayed 4 cycles → `imem_req`/`imem_addr` stable throughout; then `type`=00010, `DR`=2, `imm`=FFFF.
- Hold `dec_ready`=0 for 3 cycles → outputs frozen, `imem_req`=0. Then `dec_ready`=1 with `next_ip_valid`=1 and `next_IP`=3001 → `imem_req`=1 with `imem_addr`=3001 on the next cycle.
- Return 16'h4FFF → `imm`=FFFF, `DR`=7. Return 16'hD000 → `illegal`=1, `type`=01101. Return 16'hF025 → `imm`=0025.
- Pulse `rst_n` low during WAIT_NPC and during a FETCH wait state → immediate reset values. A subsequent `imem_valid` in RST_IDLE is not captured, and fetching restarts at `RESET_PC`.
